// File: rtl/riscv_dmem_responder_pkg.sv
// Shared types, MMIO offsets and the byte-lane merge helper for the data-port
// responder and its console FIFO.
`include "riscv_configs.v"

package riscv_dmem_responder_pkg;

  localparam int XW = `XLEN;

  localparam logic [7:0] OFF_MTIME_LO   = `DMEM_MTIME_LO;
  localparam logic [7:0] OFF_MTIME_HI   = `DMEM_MTIME_HI;
  localparam logic [7:0] OFF_CMP_LO     = `DMEM_CMP_LO;
  localparam logic [7:0] OFF_CMP_HI     = `DMEM_CMP_HI;
  localparam logic [7:0] OFF_CON_DATA   = `DMEM_CON_DATA;
  localparam logic [7:0] OFF_CON_STATUS = `DMEM_CON_STATUS;
  localparam logic [7:0] OFF_ERR        = `DMEM_ERR;

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic misaligned;
    logic outOfRange;
  } errBits_t;

  // Replace only the lanes enabled in sel with the matching bytes of wdata.
  function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  sel);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/riscv_configs.v
// Shared data-port configuration: XLEN and the MMIO register byte offsets,
// reused by software headers and benches.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN 32

`define DMEM_MTIME_LO   8'h00
`define DMEM_MTIME_HI   8'h04
`define DMEM_CMP_LO     8'h08
`define DMEM_CMP_HI     8'h0C
`define DMEM_CON_DATA   8'h10
`define DMEM_CON_STATUS 8'h14
`define DMEM_ERR        8'h18

`endif

// File: rtl/riscv_dmem_con_fifo.sv
// Synchronous console FIFO; read/write pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module riscv_dmem_con_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  output logic                     valid,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AI = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AI:0]       wrPtr;
  logic [AI:0]       rdPtr;
  logic              doPush;
  logic              doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AI] != rdPtr[AI]) && (wrPtr[AI-1:0] == rdPtr[AI-1:0]);
  assign count  = wrPtr - rdPtr;
  assign valid  = !empty;
  assign doPop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doPush = push && (!full || doPop);
  assign head   = empty ? '0 : mem[rdPtr[AI-1:0]];

  always_ff @(posedge clk) begin
    if (doPush && !rst) mem[wrPtr[AI-1:0]] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// M-stage data-port responder: byte-lane RAM, 64-bit machine timer with compare
// IRQ and a console TX FIFO. Optional sticky error reporting via RISCV_DMEM_ERR_EN.
`include "riscv_configs.v"

module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int RAM_DEPTH = 1024,
  parameter int TIMER_DIV = 1,
  parameter int CON_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [`XLEN-1:0]   i_addr,
  input  logic               i_wr_en,
  input  logic [3:0]         i_byte_sel,
  input  logic [`XLEN-1:0]   i_wdata,
  output logic [`XLEN-1:0]   o_rdata,
  output logic               o_irq_timer,
  output logic               o_con_valid,
  output logic [7:0]         o_con_data,
  input  logic               i_con_ready
`ifdef RISCV_DMEM_ERR_EN
  ,
  output logic [1:0]         o_err
`endif
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int CW = $clog2(CON_DEPTH) + 1;

  logic [XW-1:0] ramMem [RAM_DEPTH];
  logic [AW-1:0] ramIdx;
  logic          isMmio;
  logic [7:0]    mmioOff;
  logic [7:0]    regOff;
  logic          mmioWr;
  logic          ramOor;
  logic [XW-1:0] ramRdata;
  logic [XW-1:0] mmioRdata;
  logic          unusedAddrBits;

  assign isMmio  = i_addr[31];
  assign mmioOff = i_addr[7:0];
  assign regOff  = {i_addr[7:2], 2'b00};
  assign ramIdx  = i_addr[AW+1:2];
  assign mmioWr  = i_wr_en && isMmio && !i_rst;
  assign unusedAddrBits = ^i_addr;

  errBits_t errState;

`ifdef RISCV_DMEM_ERR_EN
  logic mmioOor;
  logic misalignedNow;

  assign ramOor  = !isMmio && ((i_addr[30:0] >> (AW + 2)) != 31'd0);
  assign mmioOor = isMmio && (mmioOff > OFF_ERR);
  assign misalignedNow = ((i_byte_sel == 4'b1111) && (i_addr[1:0] != 2'b00)) ||
                         (((i_byte_sel == 4'b0011) || (i_byte_sel == 4'b1100)) && i_addr[0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      errState <= '0;
    end else begin
      errState.misaligned <= errState.misaligned | misalignedNow;
      errState.outOfRange <= errState.outOfRange | ramOor | mmioOor;
    end
  end

  assign o_err = errState;
`else
  assign ramOor   = 1'b0;
  assign errState = '0;
`endif

  // RAM: per-lane write at the edge; combinational read returns pre-store contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_wr_en && !isMmio && !ramOor) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_sel[b]) ramMem[ramIdx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign ramRdata = ramOor ? '0 : ramMem[ramIdx];

  logic [PW-1:0] presc;
  logic          timerTick;
  logic [63:0]   mtime;
  logic [63:0]   mtimeCmp;
  logic [63:0]   mtimeNext;
  logic [63:0]   cmpNext;

  assign timerTick = (presc == PW'(TIMER_DIV - 1));

  // Software writes override the increment only for the half being written.
  always_comb begin
    mtimeNext = timerTick ? (mtime + 64'd1) : mtime;
    cmpNext   = mtimeCmp;
    if (mmioWr && (regOff == OFF_MTIME_LO))
      mtimeNext[31:0]  = laneMerge(mtime[31:0], i_wdata, i_byte_sel);
    if (mmioWr && (regOff == OFF_MTIME_HI))
      mtimeNext[63:32] = laneMerge(mtime[63:32], i_wdata, i_byte_sel);
    if (mmioWr && (regOff == OFF_CMP_LO))
      cmpNext[31:0]    = laneMerge(mtimeCmp[31:0], i_wdata, i_byte_sel);
    if (mmioWr && (regOff == OFF_CMP_HI))
      cmpNext[63:32]   = laneMerge(mtimeCmp[63:32], i_wdata, i_byte_sel);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc       <= '0;
      mtime       <= '0;
      mtimeCmp    <= CMP_RESET;
      o_irq_timer <= 1'b0;
    end else begin
      presc       <= timerTick ? '0 : presc + PW'(1);
      mtime       <= mtimeNext;
      mtimeCmp    <= cmpNext;
      o_irq_timer <= (mtime >= mtimeCmp);
    end
  end

  logic          conPush;
  logic          conPop;
  logic          conFull;
  logic          conEmpty;
  logic [CW-1:0] conCount;
  logic          conOverflow;
  logic          statusClr;

  assign conPush   = mmioWr && (regOff == OFF_CON_DATA) && i_byte_sel[0];
  assign conPop    = o_con_valid && i_con_ready;
  assign statusClr = mmioWr && (regOff == OFF_CON_STATUS) && i_byte_sel[0] && i_wdata[2];

  riscv_dmem_con_fifo #(
    .DEPTH  (CON_DEPTH),
    .DATA_W (8)
  ) u_conFifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (conPush),
    .pushData (i_wdata[7:0]),
    .pop      (conPop),
    .valid    (o_con_valid),
    .head     (o_con_data),
    .full     (conFull),
    .empty    (conEmpty),
    .count    (conCount)
  );

  // A dropped push re-arms overflow even if software clears it in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conOverflow <= 1'b0;
    end else if (conPush && conFull && !conPop) begin
      conOverflow <= 1'b1;
    end else if (statusClr) begin
      conOverflow <= 1'b0;
    end
  end

  always_comb begin
    mmioRdata = '0;
    case (regOff)
      OFF_MTIME_LO:   mmioRdata = mtime[31:0];
      OFF_MTIME_HI:   mmioRdata = mtime[63:32];
      OFF_CMP_LO:     mmioRdata = mtimeCmp[31:0];
      OFF_CMP_HI:     mmioRdata = mtimeCmp[63:32];
      OFF_CON_STATUS: mmioRdata = {24'd0, 4'(conCount), 1'b0, conOverflow, conEmpty, conFull};
      OFF_ERR:        mmioRdata = {30'd0, errState};
      default:        mmioRdata = '0;
    endcase
  end

  assign o_rdata = isMmio ? mmioRdata : ramRdata;

endmodule
